neorv32_uart_tx_arbiter: RTL and testbench

//  - Shares one serial UART TX line (8N1) among NUM_REQ byte-stream requesters (sim console mux, debug taps).
//  - Round-robin arbitration per byte; built-in baud counter and serializer FSM.
//  - Output frames match the format decoded by the simulation UART receiver, so benches check output byte-for-byte.

---
 rtl/neorv32_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_neorv32_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/neorv32_uart_tx_arbiter.sv
// ============================================================================
// Module   : neorv32_uart_tx_arbiter
// Function : Round-robin share of one 8N1 UART TX line among NUM_REQ byte
//            streams, with an internal baud counter and serializer FSM.
//            Optional sticky-owner lock until newline: NEORV32_UART_ARB_LOCK_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neorv32_uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 uart_txd_o
);

  localparam int BIT_CYC = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BIT_CYC - 1);
  localparam logic [RR_W-1:0]  RR_RST  = RR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 txd_q, txd_d;
`ifdef NEORV32_UART_ARB_LOCK_EN
  logic                 lock_q, lock_d;
`endif

  logic                 win_found;
  logic [RR_W-1:0]      win_idx;
  logic [RR_W-1:0]      cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [7:0]           win_byte;
  logic                 xfer;
  logic                 tick;

  // Search starts just above the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    cand      = rr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = RR_W'((int'(rr_q) + i) % NUM_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef NEORV32_UART_ARB_LOCK_EN
    if (lock_q) begin
      win_found = req_valid_i[rr_q];
      win_idx   = rr_q;
    end
`endif
  end

  always_comb begin
    win_onehot = '0;
    win_byte   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_onehot[k] = (win_idx == RR_W'(k));
      if (win_idx == RR_W'(k)) begin
        win_byte = req_data_i[k*8 +: 8];
      end
    end
  end

  assign xfer        = (state_q == S_IDLE) && win_found;
  assign req_ready_o = xfer ? win_onehot : '0;
  assign tick        = (cnt_q == CNT_TOP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    txd_d   = txd_q;
`ifdef NEORV32_UART_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (xfer) begin
          shreg_d = win_byte;
          rr_d    = win_idx;
          grant_d = win_onehot;
          busy_d  = 1'b1;
          txd_d   = 1'b0;
          state_d = S_START;
`ifdef NEORV32_UART_ARB_LOCK_EN
          lock_d  = (win_byte != 8'h0A);
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          txd_d   = shreg_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rr_q    <= RR_RST;
      grant_q <= '0;
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
`ifdef NEORV32_UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      txd_q   <= txd_d;
`ifdef NEORV32_UART_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign uart_txd_o = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_neorv32_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_neorv32_uart_tx_arbiter
// Function : Directed vector bench with a line receiver model for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neorv32_uart_tx_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 250;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic [1:0]  valid;
  logic [15:0] data;
  logic [1:0]  ready, grant;
  logic        busy, txd;

  assign valid = {v1, v0};
  assign data  = {d1, d0};

  always #5 clk = ~clk;

  neorv32_uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .grant_o(grant), .busy_o(busy), .uart_txd_o(txd)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line receiver: {stop, byte} per frame, plus high time preceding each start bit.
  logic [8:0] rxq[$];
  int         gaps[$];
  initial begin : rx
    logic [7:0] b;
    int run;
    run = 0;
    b = '0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        if (run > 0 && run <= 3*BIT) gaps.push_back(run);
        repeat (BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        rxq.push_back({txd, b});
        run = BIT/2 + 1;
      end else begin
        run++;
      end
    end
  end

  logic [1:0] gmon_exp = 2'b00;
  int         gbad = 0;
  always @(negedge clk) begin
    if (gmon_exp != 2'b00 && busy && grant !== gmon_exp) gbad <= gbad + 1;
  end

  task automatic set_req(input int k, input logic v, input logic [7:0] d);
    if (k == 0) begin v0 = v; d0 = d; end
    else        begin v1 = v; d1 = d; end
  endtask

  task automatic drive(input int k, input string s);
    int   budget;
    logic acc;
    for (int i = 0; i < s.len(); i++) begin
      budget = 0;
      acc    = 1'b0;
      @(negedge clk);
      set_req(k, 1'b1, s[i]);
      while (!acc && budget < 800) begin
        #1;
        if (ready[k]) acc = 1'b1;
        else begin
          @(negedge clk);
          budget++;
        end
      end
      if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    set_req(k, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15*BIT) @(negedge clk);
    rxq.delete();
    gaps.delete();
  endtask

  typedef struct {
    string      s0;
    string      s1;
    string      exp;
    int         n_gaps;
    logic [1:0] g;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [9:0] wave;
    int bad, bbad, w, n;

    vt[0] = '{"N", "", "N", 0, 2'b01};
`ifdef NEORV32_UART_ARB_LOCK_EN
    vt[1] = '{"AB\n", "ab\n", "AB\nab\n", 0, 2'b00};
    vt[2] = '{"NE\n", "x", "NE\nx", 0, 2'b00};
`else
    vt[1] = '{"ABC", "abc", "AaBbCc", 0, 2'b00};
    vt[2] = '{"NE\n", "x", "NxE\n", 0, 2'b00};
`endif
    vt[3] = '{"", "xyz", "xyz", 2, 2'b10};
    vt[4] = '{"NEORV32", "", "NEORV32", 6, 2'b01};

    // Reset state held with no requests
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ready", {30'd0, ready}, 32'd0);

    // Single 0x4E frame: cycle-accurate waveform and busy window
    v0 = 1'b1; d0 = 8'h4E;
    #1 chk("n_ready", {30'd0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    chk("n_busy_on", {31'd0, busy}, 32'd1);
    chk("n_grant", {30'd0, grant}, 32'd1);
    wave = 10'b1_0111_0010_0 ^ 10'b0;
    wave = {1'b1, 8'h4E, 1'b0};
    bbad = 0;
    for (int p = 0; p < 10; p++) begin
      bad = 0;
      for (int c = 0; c < BIT; c++) begin
        if (p == 5 && c == 0) begin
          v1 = 1'b1; d1 = 8'h55;
          #1 chk("ready_busy", {30'd0, ready}, 32'd0);
        end
        if (txd !== wave[p]) bad++;
        if (busy !== 1'b1) bbad++;
        @(negedge clk);
      end
      chk($sformatf("n_bit%0d", p), bad, 32'd0);
    end
    chk("n_busy_len", bbad, 32'd0);
    chk("n_busy_off", {31'd0, busy}, 32'd0);
    chk("n_grant_off", {30'd0, grant}, 32'd0);
    #1 chk("req1_turn", {30'd0, ready}, 32'd2);
    #1 v1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("withdraw_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset during data bit 3 of 0x41
    v0 = 1'b1; d0 = 8'h41;
    #1 chk("a_ready", {30'd0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (4*BIT + 1) @(negedge clk);
    chk("bit3_low", {31'd0, txd}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_txd", {31'd0, txd}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_grant", {30'd0, grant}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h30; d1 = 8'h31;
    #1 chk("arst_rr", {30'd0, ready}, 32'd1);
    #1 v0 = 1'b0; v1 = 1'b0;
    repeat (15*BIT) @(negedge clk);

    // Table of stream scenarios, checked byte-for-byte at the receiver
    for (int v = 0; v < 5; v++) begin
      do_reset();
      gbad     = 0;
      gmon_exp = vt[v].g;
      fork
        drive(0, vt[v].s0);
        drive(1, vt[v].s1);
      join
      w = 0;
      while (busy && w < 4000) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("v%0d_idle", v), {31'd0, busy}, 32'd0);
      repeat (12*BIT) @(negedge clk);
      gmon_exp = 2'b00;
      chk($sformatf("v%0d_len", v), rxq.size(), vt[v].exp.len());
      n = (rxq.size() < vt[v].exp.len()) ? rxq.size() : vt[v].exp.len();
      for (int i = 0; i < n; i++)
        chk($sformatf("v%0d_byte%0d", v, i), {23'd0, rxq[i]}, {23'd0, 1'b1, vt[v].exp[i]});
      if (vt[v].g != 2'b00)
        chk($sformatf("v%0d_grant", v), gbad, 32'd0);
      if (vt[v].n_gaps > 0) begin
        chk($sformatf("v%0d_ngaps", v), gaps.size(), vt[v].n_gaps);
        for (int i = 0; i < gaps.size(); i++)
          chk($sformatf("v%0d_gap%0d", v, i), gaps[i], BIT + 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
